// File: rtl/m1_upsample_csc.sv
// Milestone-1 engine: reads 4:2:2 YUV from SRAM, upsamples chroma with a 6-tap FIR,
// converts to RGB and writes packed RGB pairs back. Two shared multipliers do all the math.
module m1_upsample_csc #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned Y_BASE     = 0,
  parameter int unsigned U_BASE     = 38400,
  parameter int unsigned V_BASE     = 57600,
  parameter int unsigned RGB_BASE   = 146944
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        M1_Enable,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        M1_Stop
);

  localparam int unsigned HalfW  = IMG_WIDTH / 2;
  localparam int unsigned QuartW = IMG_WIDTH / 4;

  typedef enum logic [3:0] {
    StIdle, StLeadIn, StRdY, StRdUv, StWait1, StWait2, StFir, StCsc,
    StWr0, StWr1, StWr2, StRowEnd, StDone
  } state_e;

  typedef enum logic [2:0] {RdNone, RdY, RdUsh, RdVsh, RdUnew, RdVnew} rd_kind_e;

  state_e             state;
  logic               armed;
  logic [15:0]        pair_cnt, row_cnt;
  logic [3:0]         step;
  logic [17:0]        y_row_base, c_row_base, rgb_addr;
  logic [7:0]         sr_u [6];
  logic [7:0]         sr_v [6];
  logic [7:0]         y0, y1, u_new, v_new;
  logic signed [31:0] acc_u, acc_v;
  logic signed [31:0] prod [10];
  rd_kind_e           rd_kind [3];
  logic               rd_half [3];

  function automatic logic [15:0] clamp_idx(input int s);
    if (s < 0) return 16'd0;
    if (s > int'(HalfW) - 1) return 16'(HalfW - 1);
    return 16'(s);
  endfunction

  function automatic logic [7:0] clip8(input logic signed [31:0] x);
    if (x < 0) return 8'd0;
    if (x > 32'sd255) return 8'd255;
    return x[7:0];
  endfunction

  function automatic logic signed [31:0] fir_coef(input logic [2:0] t);
    case (t)
      3'd0, 3'd5: return 32'sd21;
      3'd1, 3'd4: return -32'sd52;
      default:    return 32'sd159;
    endcase
  endfunction

  logic [15:0]        c_idx;
  logic [17:0]        c_word;
  logic [7:0]         rd_byte, u_odd, v_odd;
  logic [2:0]         tap;
  logic signed [31:0] y_s [2];
  logic signed [31:0] u_s [2];
  logic signed [31:0] v_s [2];
  logic signed [31:0] op [10];
  logic signed [31:0] cf [10];
  logic signed [31:0] ma_c, ma_x, mb_c, mb_x, mul_a, mul_b;
  logic [7:0]         r0, g0, b0, r1, g1, b1;

  assign tap = step[2:0];

  // Lead-in walks clamped samples -2..3 for U then V; pairs prefetch sample k+4.
  always_comb begin
    c_idx = 16'd0;
    if (state == StLeadIn) begin
      c_idx = clamp_idx((step < 4'd6) ? int'(step) - 2 : int'(step) - 8);
    end else begin
      c_idx = clamp_idx(int'(pair_cnt) + 4);
    end
    c_word  = c_row_base + 18'(c_idx >> 1);
    rd_byte = rd_half[2] ? SRAM_read_data[7:0] : SRAM_read_data[15:8];
    u_odd   = clip8((acc_u + 32'sd128) >>> 8);
    v_odd   = clip8((acc_v + 32'sd128) >>> 8);
  end

  always_comb begin
    y_s[0] = $signed({24'd0, y0});
    y_s[1] = $signed({24'd0, y1});
    u_s[0] = $signed({24'd0, sr_u[2]});
    u_s[1] = $signed({24'd0, u_odd});
    v_s[0] = $signed({24'd0, sr_v[2]});
    v_s[1] = $signed({24'd0, v_odd});
    for (int p = 0; p < 2; p++) begin
      op[5*p]   = y_s[p] - 32'sd16;
      cf[5*p]   = 32'sd76284;
      op[5*p+1] = v_s[p] - 32'sd128;
      cf[5*p+1] = 32'sd104595;
      op[5*p+2] = u_s[p] - 32'sd128;
      cf[5*p+2] = 32'sd25624;
      op[5*p+3] = v_s[p] - 32'sd128;
      cf[5*p+3] = 32'sd53281;
      op[5*p+4] = u_s[p] - 32'sd128;
      cf[5*p+4] = 32'sd132251;
    end
  end

  always_comb begin
    ma_c = '0;
    ma_x = '0;
    mb_c = '0;
    mb_x = '0;
    if (state == StFir) begin
      ma_c = fir_coef(tap);
      ma_x = $signed({24'd0, sr_u[tap]});
      mb_c = fir_coef(tap);
      mb_x = $signed({24'd0, sr_v[tap]});
    end else if (state == StCsc && step < 4'd5) begin
      ma_c = cf[{step[2:0], 1'b0}];
      ma_x = op[{step[2:0], 1'b0}];
      mb_c = cf[{step[2:0], 1'b1}];
      mb_x = op[{step[2:0], 1'b1}];
    end
    mul_a = ma_c * ma_x;
    mul_b = mb_c * mb_x;
  end

  always_comb begin
    r0 = clip8((prod[0] + prod[1]) >>> 16);
    g0 = clip8((prod[0] - prod[2] - prod[3]) >>> 16);
    b0 = clip8((prod[0] + prod[4]) >>> 16);
    r1 = clip8((prod[5] + prod[6]) >>> 16);
    g1 = clip8((prod[5] - prod[7] - prod[8]) >>> 16);
    b1 = clip8((prod[5] + prod[9]) >>> 16);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state           <= StIdle;
      armed           <= 1'b0;
      pair_cnt        <= '0;
      row_cnt         <= '0;
      step            <= '0;
      y_row_base      <= '0;
      c_row_base      <= '0;
      rgb_addr        <= '0;
      y0              <= '0;
      y1              <= '0;
      u_new           <= '0;
      v_new           <= '0;
      acc_u           <= '0;
      acc_v           <= '0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      M1_Stop         <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        sr_u[i] <= '0;
        sr_v[i] <= '0;
      end
      for (int i = 0; i < 10; i++) prod[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        rd_kind[i] <= RdNone;
        rd_half[i] <= 1'b0;
      end
    end else begin
      SRAM_we_n  <= 1'b1;
      M1_Stop    <= 1'b0;
      // Tags follow each read through the SRAM latency to the cycle its data lands.
      rd_kind[0] <= RdNone;
      rd_kind[1] <= rd_kind[0];
      rd_kind[2] <= rd_kind[1];
      rd_half[1] <= rd_half[0];
      rd_half[2] <= rd_half[1];
      case (rd_kind[2])
        RdY: begin
          y0 <= SRAM_read_data[15:8];
          y1 <= SRAM_read_data[7:0];
        end
        RdUsh: begin
          for (int i = 0; i < 5; i++) sr_u[i] <= sr_u[i+1];
          sr_u[5] <= rd_byte;
        end
        RdVsh: begin
          for (int i = 0; i < 5; i++) sr_v[i] <= sr_v[i+1];
          sr_v[5] <= rd_byte;
        end
        RdUnew:  u_new <= rd_byte;
        RdVnew:  v_new <= rd_byte;
        default: ;
      endcase

      case (state)
        StIdle: begin
          if (!M1_Enable) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed      <= 1'b0;
            state      <= StLeadIn;
            step       <= '0;
            row_cnt    <= '0;
            pair_cnt   <= '0;
            y_row_base <= '0;
            c_row_base <= '0;
            rgb_addr   <= 18'(RGB_BASE);
          end
        end
        StLeadIn: begin
          if (step < 4'd12) begin
            SRAM_address <= ((step < 4'd6) ? 18'(U_BASE) : 18'(V_BASE)) + c_word;
            rd_kind[0]   <= (step < 4'd6) ? RdUsh : RdVsh;
            rd_half[0]   <= c_idx[0];
          end
          if (step == 4'd14) begin
            step  <= '0;
            state <= StRdY;
          end else begin
            step <= step + 4'd1;
          end
        end
        StRdY: begin
          SRAM_address <= 18'(Y_BASE) + y_row_base + 18'(pair_cnt);
          rd_kind[0]   <= RdY;
          step         <= '0;
          state        <= StRdUv;
        end
        StRdUv: begin
          rd_half[0] <= c_idx[0];
          if (step == 4'd0) begin
            SRAM_address <= 18'(U_BASE) + c_word;
            rd_kind[0]   <= RdUnew;
            step         <= 4'd1;
          end else begin
            SRAM_address <= 18'(V_BASE) + c_word;
            rd_kind[0]   <= RdVnew;
            state        <= StWait1;
          end
        end
        StWait1: state <= StWait2;
        StWait2: begin
          step  <= '0;
          state <= StFir;
        end
        StFir: begin
          acc_u <= (step == 4'd0) ? mul_a : acc_u + mul_a;
          acc_v <= (step == 4'd0) ? mul_b : acc_v + mul_b;
          if (step == 4'd5) begin
            step  <= '0;
            state <= StCsc;
          end else begin
            step <= step + 4'd1;
          end
        end
        StCsc: begin
          if (step < 4'd5) begin
            prod[{step[2:0], 1'b0}] <= mul_a;
            prod[{step[2:0], 1'b1}] <= mul_b;
            step <= step + 4'd1;
          end else begin
            SRAM_we_n       <= 1'b0;
            SRAM_address    <= rgb_addr;
            SRAM_write_data <= {r0, g0};
            rgb_addr        <= rgb_addr + 18'd1;
            state           <= StWr0;
          end
        end
        StWr0: begin
          SRAM_we_n       <= 1'b0;
          SRAM_address    <= rgb_addr;
          SRAM_write_data <= {b0, r1};
          rgb_addr        <= rgb_addr + 18'd1;
          state           <= StWr1;
        end
        StWr1: begin
          SRAM_we_n       <= 1'b0;
          SRAM_address    <= rgb_addr;
          SRAM_write_data <= {g1, b1};
          rgb_addr        <= rgb_addr + 18'd1;
          state           <= StWr2;
        end
        StWr2: begin
          for (int i = 0; i < 5; i++) begin
            sr_u[i] <= sr_u[i+1];
            sr_v[i] <= sr_v[i+1];
          end
          sr_u[5] <= u_new;
          sr_v[5] <= v_new;
          if (pair_cnt == 16'(HalfW - 1)) begin
            state <= StRowEnd;
          end else begin
            pair_cnt <= pair_cnt + 16'd1;
            state    <= StRdY;
          end
        end
        StRowEnd: begin
          pair_cnt <= '0;
          step     <= '0;
          if (row_cnt == 16'(IMG_HEIGHT - 1)) begin
            M1_Stop <= 1'b1;
            state   <= StDone;
          end else begin
            row_cnt    <= row_cnt + 16'd1;
            y_row_base <= y_row_base + 18'(HalfW);
            c_row_base <= c_row_base + 18'(QuartW);
            state      <= StLeadIn;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_m1_upsample_csc.sv
// Bench for m1_upsample_csc on a small frame: SRAM model with 2-cycle read latency and a
// write scoreboard filled from a reference model of the upsample/CSC maths.
module tb_m1_upsample_csc;

  localparam int W  = 8;
  localparam int H  = 12;
  localparam int YB = 0;
  localparam int UB = 64;
  localparam int VB = 96;
  localparam int RB = 128;
  localparam int WORDS = W * H * 3 / 2;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        M1_Enable;
  logic [15:0] SRAM_read_data = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        M1_Stop;

  m1_upsample_csc #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .Y_BASE    (YB),
    .U_BASE    (UB),
    .V_BASE    (VB),
    .RGB_BASE  (RB)
  ) dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .M1_Enable      (M1_Enable),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .M1_Stop        (M1_Stop)
  );

  always #5 Clock = ~Clock;

  logic [15:0] mem [0:511];
  logic [33:0] sb [$];
  logic [8:0]  p1 = '0, p2 = '0;
  int n_cmp = 0, n_err = 0, stop_cnt = 0, wr_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SRAM: address seen in cycle c returns data during cycle c+2.
  always @(negedge Clock) begin
    logic [33:0] e;
    if (M1_Stop) stop_cnt++;
    if (!SRAM_we_n) begin
      mem[SRAM_address[8:0]] = SRAM_write_data;
      wr_cnt++;
      if (sb.size() == 0) begin
        check_eq("spurious_wr_addr", 32'(SRAM_address), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_eq("wr_addr", 32'(SRAM_address), 32'(e[33:16]));
        check_eq("wr_data", 32'(SRAM_write_data), 32'(e[15:0]));
      end
    end
    SRAM_read_data = mem[p2];
    p2 = p1;
    p1 = SRAM_address[8:0];
  end

  function automatic logic [7:0] clip8(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
  endfunction

  function automatic int chroma(input int base, input int r, input int idx);
    logic [15:0] w;
    int i;
    i = (idx < 0) ? 0 : ((idx > W / 2 - 1) ? W / 2 - 1 : idx);
    w = mem[base + r * (W / 4) + i / 2];
    return (i % 2 == 1) ? int'(w[7:0]) : int'(w[15:8]);
  endfunction

  function automatic int fir(input int base, input int r, input int a);
    int s;
    s = 21 * chroma(base, r, a - 2) - 52 * chroma(base, r, a - 1)
      + 159 * chroma(base, r, a) + 159 * chroma(base, r, a + 1)
      - 52 * chroma(base, r, a + 2) + 21 * chroma(base, r, a + 3) + 128;
    return int'(clip8(s >>> 8));
  endfunction

  function automatic logic [23:0] csc(input int y, input int u, input int v);
    int c;
    c = 76284 * (y - 16);
    return {clip8((c + 104595 * (v - 128)) >>> 16),
            clip8((c - 25624 * (u - 128) - 53281 * (v - 128)) >>> 16),
            clip8((c + 132251 * (u - 128)) >>> 16)};
  endfunction

  task automatic push_frame();
    for (int r = 0; r < H; r++) begin
      for (int k = 0; k < W / 2; k++) begin
        logic [15:0] yw;
        logic [23:0] p0, q1;
        int base;
        yw   = mem[YB + r * (W / 2) + k];
        p0   = csc(int'(yw[15:8]), chroma(UB, r, k), chroma(VB, r, k));
        q1   = csc(int'(yw[7:0]), fir(UB, r, k), fir(VB, r, k));
        base = RB + 3 * (r * (W / 2) + k);
        sb.push_back({18'(base), p0[23:8]});
        sb.push_back({18'(base + 1), p0[7:0], q1[23:16]});
        sb.push_back({18'(base + 2), q1[15:0]});
      end
    end
  endtask

  task automatic fill(input int yv, input int uv, input int vv, input bit rnd);
    logic [7:0] a, b;
    for (int i = 0; i < W * H / 2; i++) begin
      a = rnd ? 8'($urandom) : 8'(yv);
      b = rnd ? 8'($urandom) : 8'(yv);
      mem[YB + i] = {a, b};
    end
    for (int i = 0; i < W * H / 4; i++) begin
      a = rnd ? 8'($urandom) : 8'(uv);
      b = rnd ? 8'($urandom) : 8'(uv);
      mem[UB + i] = {a, b};
      a = rnd ? 8'($urandom) : 8'(vv);
      b = rnd ? 8'($urandom) : 8'(vv);
      mem[VB + i] = {a, b};
    end
  endtask

  task automatic run_frame(input bit hold, input string tag);
    int s0, w0;
    bit done;
    push_frame();
    s0 = stop_cnt;
    w0 = wr_cnt;
    M1_Enable = 1'b0;
    @(negedge Clock);
    M1_Enable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 8000 && !done; i++) begin
      @(negedge Clock);
      if (stop_cnt != s0) done = 1'b1;
    end
    repeat (4) @(negedge Clock);
    check_eq({tag, "_stop_pulses"}, 32'(stop_cnt - s0), 32'd1);
    check_eq({tag, "_write_count"}, 32'(wr_cnt - w0), 32'(WORDS));
    check_eq({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    sb.delete();
    if (!hold) M1_Enable = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    int s0, w0;
    bit hit;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    Resetn    = 1'b0;
    M1_Enable = 1'b0;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    check_eq("rst_we_n", 32'(SRAM_we_n), 32'd1);
    check_eq("rst_addr", 32'(SRAM_address), 32'd0);
    check_eq("rst_wdata", 32'(SRAM_write_data), 32'd0);
    check_eq("rst_stop", 32'(M1_Stop), 32'd0);

    fill(16, 128, 128, 1'b0);
    run_frame(1'b0, "black");

    fill(235, 128, 128, 1'b0);
    run_frame(1'b0, "white");
    w = mem[RB + WORDS - 1];
    check_eq("white_last_word", 32'(w), 32'hFEFE);

    fill(255, 128, 255, 1'b0);
    run_frame(1'b0, "clip");
    w = mem[RB];
    check_eq("clip_w0", 32'(w), 32'hFFAE);
    w = mem[RB + 1];
    check_eq("clip_w1", 32'(w), 32'hFFFF);
    w = mem[RB + 2];
    check_eq("clip_w2", 32'(w), 32'hAEFF);

    fill(16, 0, 128, 1'b0);
    mem[UB] = 16'hFF00;
    run_frame(1'b0, "impulse");
    w = mem[RB + 1];
    check_eq("imp_b_px0", 32'(w[15:8]), 32'h00FF);
    w = mem[RB + 2];
    check_eq("imp_g_px1", 32'(w[15:8]), 32'h0000);
    w = mem[RB + 5];
    check_eq("imp_g_px3", 32'(w[15:8]), 32'h0032);
    w = mem[RB + 8];
    check_eq("imp_g_px5", 32'(w[15:8]), 32'h0029);

    // Abort mid row 10, then restart and expect a complete, exact frame.
    fill(0, 0, 0, 1'b1);
    push_frame();
    s0 = stop_cnt;
    M1_Enable = 1'b0;
    @(negedge Clock);
    M1_Enable = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 8000 && !hit; i++) begin
      @(negedge Clock);
      if (!SRAM_we_n && SRAM_address == 18'(RB + 10 * 3 * W / 2 + 4)) hit = 1'b1;
    end
    check_eq("abort_reached_row10", 32'(hit), 32'd1);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    check_eq("abort_we_n", 32'(SRAM_we_n), 32'd1);
    check_eq("abort_addr", 32'(SRAM_address), 32'd0);
    check_eq("abort_stop", 32'(M1_Stop), 32'd0);
    sb.delete();
    repeat (20) @(negedge Clock);
    check_eq("abort_no_stop", 32'(stop_cnt - s0), 32'd0);
    run_frame(1'b0, "restart");

    fill(0, 0, 0, 1'b1);
    run_frame(1'b1, "hold");
    s0 = stop_cnt;
    w0 = wr_cnt;
    repeat (1000) @(negedge Clock);
    check_eq("hold_no_writes", 32'(wr_cnt - w0), 32'd0);
    check_eq("hold_no_stop", 32'(stop_cnt - s0), 32'd0);
    run_frame(1'b0, "rearm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
